// File: rtl/axis_frame_source_pkg.sv
// Shared types and constants for the AXI-Stream frame source.
// State and mode encodings, dimension width, control-word builder.
package axis_frame_source_pkg;

  localparam int DIM_W = 12;
  localparam logic [31:0] CNTRL_MAGIC_DEF = 32'hA000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CNTRL,
    S_MM2S
  } state_t;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_RAMP   = 2'd1,
    MODE_YX     = 2'd2,
    MODE_RAMP3  = 2'd3
  } mode_t;

  function automatic logic [31:0] ctrl_word(
    input logic [7:0]       idx,
    input logic [31:0]      magic,
    input logic [DIM_W-1:0] h,
    input logic [DIM_W-1:0] w,
    input logic [31:0]      seq
  );
    logic [31:0] r;
    case (idx)
      8'd0:    r = magic;
      8'd1:    r = {h, w, 8'h00};
      8'd2:    r = seq;
      default: r = magic | {24'h0, idx};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-deep valid/ready output register; payload held while stalled.
// Ports: i_valid/o_ready/i_data upstream, o_valid/i_ready/o_data downstream.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/axis_frame_source.sv
// AXI-Stream frame source: control packet then one image frame, repeated.
// Ports: start/stop/cfg_* control, s_data upstream, mm2s/cntrl out, busy, frame_done.
module axis_frame_source
  import axis_frame_source_pkg::*;
#(
  parameter int          MM2S_TDATA_WIDTH  = 32,
  parameter int          CNTRL_TDATA_WIDTH = 32,
  parameter int          CNTRL_WORDS       = 6,
  parameter logic [31:0] CNTRL_MAGIC       = CNTRL_MAGIC_DEF
) (
  input  logic                            m_axis_mm2s_aclk,
  input  logic                            m_axis_mm2s_aresetn,
  input  logic                            start,
  input  logic                            stop,
  input  logic [DIM_W-1:0]                cfg_width,
  input  logic [DIM_W-1:0]                cfg_height,
  input  logic [15:0]                     cfg_frames,
  input  logic [1:0]                      cfg_mode,
  input  logic                            s_data_tvalid,
  input  logic [MM2S_TDATA_WIDTH-1:0]     s_data_tdata,
  output logic                            s_data_tready,
  input  logic                            m_axis_mm2s_tready,
  output logic [MM2S_TDATA_WIDTH-1:0]     m_axis_mm2s_tdata,
  output logic [MM2S_TDATA_WIDTH/8-1:0]   m_axis_mm2s_tkeep,
  output logic                            m_axis_mm2s_tuser,
  output logic                            m_axis_mm2s_tlast,
  output logic                            m_axis_mm2s_tvalid,
  input  logic                            m_axis_cntrl_tready,
  output logic [CNTRL_TDATA_WIDTH-1:0]    m_axis_cntrl_tdata,
  output logic [CNTRL_TDATA_WIDTH/8-1:0]  m_axis_cntrl_tkeep,
  output logic                            m_axis_cntrl_tlast,
  output logic                            m_axis_cntrl_tvalid,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int DW = MM2S_TDATA_WIDTH;
  localparam int CW = CNTRL_TDATA_WIDTH;
  localparam int PW = 2 * DIM_W;
  localparam logic [7:0] LASTW = 8'(CNTRL_WORDS - 1);

  state_t           r_state, w_next;
  mode_t            r_mode;
  logic [DIM_W-1:0] r_w, r_h, r_x, r_y;
  logic [PW-1:0]    r_total, r_bidx;
  logic [15:0]      r_fleft;
  logic             r_cont, r_stop, r_done;
  logic [7:0]       r_cidx;
  logic [31:0]      r_seq;

  logic          w_start_ok, w_c_hs_last, w_d_hs_last;
  logic          w_c_rdy, w_d_rdy, w_cont, w_remain, w_pat;
  logic          w_c_push, w_c_first, w_d_push;
  logic [7:0]    w_c_idx;
  logic [CW-1:0] w_c_word;
  logic          w_c_last;
  logic [DW-1:0] w_d_data;
  logic          w_d_user, w_d_last;
  logic [CW:0]   w_c_q;
  logic [DW+1:0] w_d_q;

  assign w_start_ok  = (r_state == S_IDLE) & start
                     & (|cfg_width) & (|cfg_height);
  assign w_c_hs_last = m_axis_cntrl_tvalid & m_axis_cntrl_tready
                     & m_axis_cntrl_tlast;
  assign w_d_hs_last = (r_state == S_MM2S) & m_axis_mm2s_tvalid
                     & m_axis_mm2s_tready & m_axis_mm2s_tlast;
  // stop seen in the tlast cycle itself also ends the sequence
  assign w_cont   = !(r_stop | stop) & (r_cont | (r_fleft > 16'd1));
  assign w_remain = r_bidx != r_total;
  assign w_pat    = r_mode != MODE_STREAM;

  assign w_c_word = CW'(ctrl_word(w_c_idx, CNTRL_MAGIC, r_h, r_w, r_seq));
  assign w_c_last = w_c_idx == LASTW;
  assign w_d_data = (r_mode == MODE_YX) ? DW'({r_y, r_x})
                  : w_pat ? DW'(r_bidx) : s_data_tdata;
  assign w_d_user = r_bidx == '0;
  assign w_d_last = r_bidx == r_total - PW'(1);

  // Pushes are issued in the same cycle as the handshake that ends
  // the previous packet, so streams run back-to-back.
  always_comb begin
    w_next        = r_state;
    w_c_push      = 1'b0;
    w_c_first     = 1'b0;
    w_c_idx       = r_cidx;
    w_d_push      = 1'b0;
    s_data_tready = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next    = S_CNTRL;
          w_c_push  = 1'b1;
          w_c_first = 1'b1;
          w_c_idx   = '0;
        end
      end
      S_CNTRL: begin
        w_c_push = (r_cidx <= LASTW) & w_c_rdy;
        if (w_c_hs_last) begin
          w_next   = S_MM2S;
          w_d_push = w_pat;
        end
      end
      S_MM2S: begin
        s_data_tready = !w_pat & w_remain & w_d_rdy;
        w_d_push = w_remain & w_d_rdy & (w_pat | s_data_tvalid);
        if (w_d_hs_last) begin
          w_next    = w_cont ? S_CNTRL : S_IDLE;
          w_c_push  = w_cont;
          w_c_first = w_cont;
          w_c_idx   = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
    if (!m_axis_mm2s_aresetn) r_state <= S_IDLE;
    else                      r_state <= w_next;
  end

  always_ff @(posedge m_axis_mm2s_aclk or negedge m_axis_mm2s_aresetn) begin
    if (!m_axis_mm2s_aresetn) begin
      r_mode  <= MODE_STREAM;
      r_w     <= '0;
      r_h     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_total <= '0;
      r_bidx  <= '0;
      r_fleft <= '0;
      r_cont  <= 1'b0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      r_cidx  <= '0;
      r_seq   <= '0;
    end else begin
      r_done <= w_d_hs_last;
      if (w_start_ok) begin
        r_mode  <= mode_t'(cfg_mode);
        r_w     <= cfg_width;
        r_h     <= cfg_height;
        r_total <= PW'(cfg_width) * PW'(cfg_height);
        r_fleft <= cfg_frames;
        r_cont  <= cfg_frames == 16'd0;
      end
      if (r_state == S_IDLE)      r_stop <= w_start_ok & stop;
      else if (w_next == S_IDLE)  r_stop <= 1'b0;
      else                        r_stop <= r_stop | stop;
      if (w_c_push) r_cidx <= w_c_idx + 8'd1;
      if (w_c_first) begin
        r_bidx <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_d_push) begin
        r_bidx <= r_bidx + PW'(1);
        if (r_x == r_w - 1'b1) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (w_d_hs_last) begin
        r_seq   <= r_seq + 32'd1;
        r_fleft <= r_fleft - 16'd1;
      end
    end
  end

  axis_reg_slice #(.W(CW + 1)) u_cntrl (
    .clk     (m_axis_mm2s_aclk),
    .rst_n   (m_axis_mm2s_aresetn),
    .i_valid (w_c_push),
    .o_ready (w_c_rdy),
    .i_data  ({w_c_last, w_c_word}),
    .o_valid (m_axis_cntrl_tvalid),
    .i_ready (m_axis_cntrl_tready),
    .o_data  (w_c_q)
  );

  axis_reg_slice #(.W(DW + 2)) u_mm2s (
    .clk     (m_axis_mm2s_aclk),
    .rst_n   (m_axis_mm2s_aresetn),
    .i_valid (w_d_push),
    .o_ready (w_d_rdy),
    .i_data  ({w_d_user, w_d_last, w_d_data}),
    .o_valid (m_axis_mm2s_tvalid),
    .i_ready (m_axis_mm2s_tready),
    .o_data  (w_d_q)
  );

  assign m_axis_cntrl_tlast = w_c_q[CW];
  assign m_axis_cntrl_tdata = w_c_q[CW-1:0];
  assign m_axis_cntrl_tkeep = '1;
  assign m_axis_mm2s_tuser  = w_d_q[DW+1];
  assign m_axis_mm2s_tlast  = w_d_q[DW];
  assign m_axis_mm2s_tdata  = w_d_q[DW-1:0];
  assign m_axis_mm2s_tkeep  = '1;
  assign busy       = r_state != S_IDLE;
  assign frame_done = r_done;

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source.
// Directed steps with random ready/valid against a frame-level model.
module tb_axis_frame_source;

  localparam logic [31:0] MAGIC = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [11:0] cfg_width = '0, cfg_height = '0;
  logic [15:0] cfg_frames = '0;
  logic [1:0]  cfg_mode = '0;
  logic        s_data_tvalid = 1'b0;
  logic [31:0] s_data_tdata = '0;
  logic        s_data_tready;
  logic        m_axis_mm2s_tready = 1'b0;
  logic [31:0] m_axis_mm2s_tdata;
  logic [3:0]  m_axis_mm2s_tkeep;
  logic        m_axis_mm2s_tuser, m_axis_mm2s_tlast, m_axis_mm2s_tvalid;
  logic        m_axis_cntrl_tready = 1'b0;
  logic [31:0] m_axis_cntrl_tdata;
  logic [3:0]  m_axis_cntrl_tkeep;
  logic        m_axis_cntrl_tlast, m_axis_cntrl_tvalid;
  logic        busy, frame_done;

  always #5 clk = ~clk;

  axis_frame_source dut (
    .m_axis_mm2s_aclk    (clk),
    .m_axis_mm2s_aresetn (rst_n),
    .start               (start),
    .stop                (stop),
    .cfg_width           (cfg_width),
    .cfg_height          (cfg_height),
    .cfg_frames          (cfg_frames),
    .cfg_mode            (cfg_mode),
    .s_data_tvalid       (s_data_tvalid),
    .s_data_tdata        (s_data_tdata),
    .s_data_tready       (s_data_tready),
    .m_axis_mm2s_tready  (m_axis_mm2s_tready),
    .m_axis_mm2s_tdata   (m_axis_mm2s_tdata),
    .m_axis_mm2s_tkeep   (m_axis_mm2s_tkeep),
    .m_axis_mm2s_tuser   (m_axis_mm2s_tuser),
    .m_axis_mm2s_tlast   (m_axis_mm2s_tlast),
    .m_axis_mm2s_tvalid  (m_axis_mm2s_tvalid),
    .m_axis_cntrl_tready (m_axis_cntrl_tready),
    .m_axis_cntrl_tdata  (m_axis_cntrl_tdata),
    .m_axis_cntrl_tkeep  (m_axis_cntrl_tkeep),
    .m_axis_cntrl_tlast  (m_axis_cntrl_tlast),
    .m_axis_cntrl_tvalid (m_axis_cntrl_tvalid),
    .busy                (busy),
    .frame_done          (frame_done)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [32:0] q_c[$], e_c[$];
  logic [33:0] q_d[$], e_d[$];
  logic [31:0] slist[$];
  int sidx = 0;
  int p_m = 100, p_c = 100, p_s = 100;
  int cur_total = 0, cur_mode = 1;
  int n_fd = 0;
  logic pm_st = 0, pc_st = 0, prev_lhs = 0, in_data = 0;
  logic [33:0] pm_v = '0;
  logic [32:0] pc_v = '0;
  int s_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, then drive new inputs after posedge.
  task automatic tick();
    logic hs;
    @(negedge clk);
    if (!rst_n) begin
      pm_st = 0; pc_st = 0; prev_lhs = 0; in_data = 0; s_cnt = 0;
    end else begin
      chk("frame_done_timing", frame_done, prev_lhs);
      if (frame_done) n_fd++;
      if (pm_st) begin
        chk("mm2s_hold_valid", m_axis_mm2s_tvalid, 1);
        chk("mm2s_hold_data", {m_axis_mm2s_tuser, m_axis_mm2s_tlast,
                               m_axis_mm2s_tdata}, pm_v);
      end
      if (pc_st) begin
        chk("cntrl_hold_valid", m_axis_cntrl_tvalid, 1);
        chk("cntrl_hold_data", {m_axis_cntrl_tlast, m_axis_cntrl_tdata}, pc_v);
      end
      chk("s_rdy_window", s_data_tready
          & !(in_data && s_cnt < cur_total && cur_mode == 0), 0);
      if (m_axis_cntrl_tvalid & m_axis_cntrl_tready) begin
        q_c.push_back({m_axis_cntrl_tlast, m_axis_cntrl_tdata});
        if (m_axis_cntrl_tlast) in_data = 1;
      end
      if (m_axis_mm2s_tvalid & m_axis_mm2s_tready)
        q_d.push_back({m_axis_mm2s_tuser, m_axis_mm2s_tlast,
                       m_axis_mm2s_tdata});
      if (s_data_tvalid & s_data_tready) s_cnt++;
      prev_lhs = m_axis_mm2s_tvalid & m_axis_mm2s_tready & m_axis_mm2s_tlast;
      if (prev_lhs) begin in_data = 0; s_cnt = 0; end
      pm_st = m_axis_mm2s_tvalid & !m_axis_mm2s_tready;
      pm_v  = {m_axis_mm2s_tuser, m_axis_mm2s_tlast, m_axis_mm2s_tdata};
      pc_st = m_axis_cntrl_tvalid & !m_axis_cntrl_tready;
      pc_v  = {m_axis_cntrl_tlast, m_axis_cntrl_tdata};
    end
    hs = s_data_tvalid & s_data_tready;
    @(posedge clk);
    #1;
    if (hs) sidx++;
    m_axis_mm2s_tready  = int'($urandom_range(99)) < p_m;
    m_axis_cntrl_tready = int'($urandom_range(99)) < p_c;
    s_data_tvalid = (sidx < slist.size()) && (int'($urandom_range(99)) < p_s);
    s_data_tdata  = (sidx < slist.size()) ? slist[sidx] : 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    q_c.delete(); q_d.delete(); e_c.delete(); e_d.delete();
    slist.delete(); sidx = 0; n_fd = 0;
    s_data_tvalid = 0; start = 0; stop = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();
  endtask

  task automatic setup(input int w, input int h, input int fr,
                       input int md, input int pm, input int pc);
    cfg_width = 12'(w); cfg_height = 12'(h);
    cfg_frames = 16'(fr); cfg_mode = 2'(md);
    cur_total = w * h; cur_mode = md;
    p_m = pm; p_c = pc;
    m_axis_mm2s_tready = pm >= 100;
    m_axis_cntrl_tready = pc >= 100;
  endtask

  task automatic kick();
    start = 1;
    tick();
    start = 0;
  endtask

  // Reference: what one frame must look like on both streams.
  task automatic exp_frame(input int md, input int w, input int h,
                           input int seq);
    logic [31:0] wd;
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      wd = MAGIC;
      else if (k == 1) wd = 32'((h << 20) | (w << 8));
      else if (k == 2) wd = 32'(seq);
      else             wd = MAGIC | 32'(k);
      e_c.push_back({k == 5, wd});
    end
    for (int i = 0; i < w * h; i++) begin
      if (md == 0)      wd = slist[i];
      else if (md == 2) wd = 32'(((i / w) << 12) | (i % w));
      else              wd = 32'(i);
      e_d.push_back({i == 0, i == w * h - 1, wd});
    end
  endtask

  task automatic run_idle(input string t, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({t, "_timeout"}, busy, 0);
    tick();
    tick();
  endtask

  task automatic compare(input string t, input int nfd);
    int n;
    chk({t, "_ncw"}, q_c.size(), e_c.size());
    chk({t, "_nbeats"}, q_d.size(), e_d.size());
    chk({t, "_frame_done"}, n_fd, nfd);
    n = (q_c.size() < e_c.size()) ? q_c.size() : e_c.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_cw%0d", t, i), q_c[i], e_c[i]);
    n = (q_d.size() < e_d.size()) ? q_d.size() : e_d.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_beat%0d", t, i), q_d[i], e_d[i]);
  endtask

  initial begin
    int cyc;
    // reset state
    repeat (2) tick();
    chk("rst_mm2s_valid", m_axis_mm2s_tvalid, 0);
    chk("rst_cntrl_valid", m_axis_cntrl_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_tdata", m_axis_mm2s_tdata, 0);
    chk("rst_flags", {m_axis_mm2s_tuser, m_axis_mm2s_tlast,
                      m_axis_cntrl_tlast, s_data_tready}, 0);

    // mode 1, 4x2, single frame, full rate, latency
    do_reset();
    setup(4, 2, 1, 1, 100, 100);
    exp_frame(1, 4, 2, 0);
    kick();
    chk("t1_word0_valid", m_axis_cntrl_tvalid, 1);
    chk("t1_word0_data", m_axis_cntrl_tdata, MAGIC);
    cfg_width = 12'd7; cfg_height = 12'd5; cfg_mode = 2'd2;
    cyc = 1;
    while (!frame_done && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("t1_latency", cyc, 6 + 8 + 1);
    run_idle("t1", 50);
    compare("t1", 1);

    // mode 2, 3x3, random ready on both streams
    do_reset();
    setup(3, 3, 1, 2, 50, 50);
    exp_frame(2, 3, 3, 0);
    kick();
    run_idle("t2", 400);
    compare("t2", 1);

    // mode 0, 4x4, bursty upstream
    do_reset();
    setup(4, 4, 1, 0, 70, 100);
    p_s = 40;
    for (int i = 0; i < 16; i++) slist.push_back($urandom);
    exp_frame(0, 4, 4, 0);
    kick();
    run_idle("t3", 600);
    compare("t3", 1);
    chk("t3_consumed", sidx, 16);
    p_s = 100;

    // continuous, stop during frame 2
    do_reset();
    setup(3, 3, 0, 1, 100, 100);
    for (int f = 0; f < 3; f++) exp_frame(1, 3, 3, f);
    kick();
    cyc = 0;
    while (q_d.size() < 21 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t4_reach_frame2", q_d.size() >= 21, 1);
    stop = 1;
    tick();
    stop = 0;
    run_idle("t4", 200);
    compare("t4", 3);

    // start and stop together: exactly one frame
    do_reset();
    setup(2, 2, 0, 2, 100, 100);
    exp_frame(2, 2, 2, 0);
    stop = 1;
    kick();
    stop = 0;
    run_idle("t5", 100);
    compare("t5", 1);

    // frame count 3, mode 3 ramp, random ready
    do_reset();
    setup(2, 1, 3, 3, 60, 60);
    for (int f = 0; f < 3; f++) exp_frame(3, 2, 1, f);
    kick();
    run_idle("t6", 600);
    compare("t6", 3);

    // zero width ignores start
    do_reset();
    setup(0, 3, 1, 1, 100, 100);
    kick();
    repeat (10) tick();
    chk("t7_busy", busy, 0);
    chk("t7_no_cntrl", q_c.size(), 0);
    chk("t7_no_data", q_d.size(), 0);

    // asynchronous reset mid-frame, then fresh start
    do_reset();
    setup(4, 4, 1, 1, 100, 100);
    kick();
    cyc = 0;
    while (q_d.size() < 5 && cyc < 100) begin
      tick();
      cyc++;
    end
    #2;
    rst_n = 0;
    #1;
    chk("t8_mm2s_valid", m_axis_mm2s_tvalid, 0);
    chk("t8_cntrl_valid", m_axis_cntrl_tvalid, 0);
    chk("t8_busy", busy, 0);
    chk("t8_tdata", m_axis_mm2s_tdata, 0);
    q_c.delete(); q_d.delete(); n_fd = 0;
    repeat (3) tick();
    rst_n = 1;
    repeat (10) tick();
    chk("t8_quiet_cntrl", q_c.size(), 0);
    chk("t8_quiet_data", q_d.size(), 0);
    chk("t8_quiet_busy", busy, 0);
    setup(2, 2, 1, 1, 100, 100);
    exp_frame(1, 2, 2, 0);
    kick();
    run_idle("t8", 100);
    compare("t8", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_frame_source.md
# axis_frame_source

- Parametrised AXI-Stream frame generator for simulation and bring-up.
- Per frame, emits a control packet on the cntrl stream, then one image frame on the mm2s stream.
- Frame data comes from an upstream stream or an internal test pattern.
- Both streams honour tready, and frames repeat under a frame count or stop request.
- Sits in place of the DMA MM2S side in front of the image-processing pipeline.

## Interface
Parameters:
- MM2S_TDATA_WIDTH, 32, data beat width (multiple of 8, ≥32).
- CNTRL_TDATA_WIDTH, 32, control word width (fixed 32).
- CNTRL_WORDS, 6, words per control packet (≥3).
- CNTRL_MAGIC, 32'hA000_0000, control header constant.

Ports:
- m_axis_mm2s_aclk  in  1  clock.
- m_axis_mm2s_aresetn  in  1  reset; asynchronous, active-low.
- start  in  1  begin sequence (sampled in IDLE).
- stop  in  1  finish current frame, then IDLE.
- cfg_width  in  12  beats per line.
- cfg_height  in  12  lines per frame.
- cfg_frames  in  16  frames to send; 0 = continuous.
- cfg_mode  in  2  data source: 0 stream, 1 ramp, 2 {y,x}, 3 = ramp.
- s_data_tvalid  in  1  upstream data valid.
- s_data_tdata  in  MM2S_TDATA_WIDTH  upstream data.
- s_data_tready  out  1  upstream ready.
- m_axis_mm2s_tready  in  1  downstream ready.
- m_axis_mm2s_tdata  out  MM2S_TDATA_WIDTH  frame data.
- m_axis_mm2s_tkeep  out  MM2S_TDATA_WIDTH/8  all ones.
- m_axis_mm2s_tuser  out  1  first beat of frame.
- m_axis_mm2s_tlast  out  1  last beat of frame.
- m_axis_mm2s_tvalid  out  1  data valid.
- m_axis_cntrl_tready  in  1  control ready.
- m_axis_cntrl_tdata  out  32  control word.
- m_axis_cntrl_tkeep  out  4  4'hF.
- m_axis_cntrl_tlast  out  1  last control word.
- m_axis_cntrl_tvalid  out  1  control valid.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.

## Operation
- **States:**
  - IDLE → CNTRL on start when cfg_width≠0 and cfg_height≠0; zero dims ignore start.
  - CNTRL → MM2S after handshake of word CNTRL_WORDS-1.
  - MM2S → CNTRL after tlast handshake if frames remain and stop not seen; otherwise → IDLE.
- **Config:** cfg_* latched on start; later changes are ignored until the next start.
- **stop:** sets a sticky flag, cleared on entry to IDLE.
- **Control words** (frame_seq starts at 0, +1 per frame, wraps at 2^32):
  - word0 = CNTRL_MAGIC.
  - word1 = {height, width, 8'h00}.
  - word2 = frame_seq.
  - word k≥3 = CNTRL_MAGIC | k.
  - tlast only on the final word.
- **Data beats:** width×height beats per frame, x/y counters (x wraps at width-1, y increments).
  - tuser on x=0,y=0; tlast on x=width-1,y=height-1.
  - Mode 1: ramp = beat index within frame, reset per frame, zero-extended.
  - Mode 2: {y,x} zero-extended.
  - Mode 0: s_data_tready = (state==MM2S) & beats remain & (!tvalid | tready). Each s_data handshake loads one beat. s_data_tready=0 in all other states and modes.
- **Frame count:** cfg_frames=N>0 → exactly N frames, then IDLE.
- **Reset values:** all valids, tlast, tuser, s_data_tready, busy, frame_done = 0; tdata = 0; state IDLE; counters and frame_seq 0.

## Timing
- Both outputs are registered. A beat loads when !tvalid | tready. tdata, tlast and tuser are held stable while tvalid & !tready.
- start in cycle n → cntrl tvalid with word0 at n+1.
- Back-to-back control words at full rate under constant tready.
- First pattern beat is valid the cycle after the last control handshake, then 1 beat/cycle under constant tready.
- Mode 0: output beat is valid the cycle after its s_data handshake, giving full throughput.
- frame_done pulses the cycle after the tlast handshake. The next frame's word0 is valid in that same cycle.
- Asynchronous reset mid-frame: outputs drop to reset values immediately. No partial packet is completed after release.
- start while busy is ignored. start and stop in the same IDLE cycle: one frame is sent, then IDLE.

## Structure
- Package axis_frame_source_pkg holds:
  - state enum (IDLE, CNTRL, MM2S);
  - mode encodings;
  - DIM_W=12;
  - default CNTRL_MAGIC.
- Sub-module axis_reg_slice: one-deep valid/ready output register, parametrised width, instantiated for mm2s (data+tuser+tlast) and cntrl (data+tlast).

## Test plan
- Mode 1, 4×2, cfg_frames=1, tready=1:
  - 6 control words A0000000, {12'd2,12'd4,8'd0}=0x00200400, 0, A0000003, A0000004, A0000005, with tlast on word5;
  - 8 data beats 0..7, tuser on beat 0, tlast on beat 7;
  - one frame_done pulse, then busy=0.
- Random tready on both streams (mode 2, 3×3): no data change while stalled; beats {0,0},{0,1}..{2,2} in order.
- Mode 0 with bursty s_data_tvalid: output equals input sequence; s_data_tready never high outside MM2S or after the 16th beat of a 4×4 frame.
- cfg_frames=0, stop asserted mid-frame 2: frames 0..2 complete, word2=0,1,2, then IDLE.
- start with cfg_width=0 → no activity. Reset asserted mid-frame → all valids 0 in the same cycle; fresh start yields frame_seq 0.
